// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, scaling, shift schedule and atanh table for the CORDIC engines
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITERATE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // z and constants carry N-FRAC_OFFSET fraction bits, so 1.0 = 2^(N-3)
  localparam int FRAC_OFFSET = 3;

  // atanh(2^-s) scaled by 2^ATANH_Q; rescaled with rounding to the datapath width on lookup
  localparam int ATANH_Q = 29;
  localparam logic [31:0] ATANH_Q29 [16] = '{
    32'd0,
    32'd294906491,
    32'd137123709,
    32'd67461703,
    32'd33598225,
    32'd16782681,
    32'd8389291,
    32'd4194389,
    32'd2097163,
    32'd1048577,
    32'd524288,
    32'd262144,
    32'd131072,
    32'd65536,
    32'd32768,
    32'd16384
  };

  function automatic logic [63:0] atanh_scaled(input logic [3:0] s, input int frac);
    logic [63:0] v;
    int          sh;
    v  = {32'd0, ATANH_Q29[s]};
    sh = ATANH_Q - frac;
    if (sh > 0) begin
      return (v + (64'd1 << (sh - 1))) >> sh;
    end
    return v << (-sh);
  endfunction

  // Hyperbolic schedule: 1,2,3,4,4,5,... when the repeat is enabled, otherwise 1,2,3,...
  function automatic logic [3:0] step_shift(input logic [4:0] step, input bit repeat4);
    if (repeat4 && (step >= 5'd4)) begin
      return step[3:0];
    end
    return step[3:0] + 4'd1;
  endfunction

endpackage

// File: rtl/cordic_iter_sequencer_if.sv
// rtl/cordic_iter_sequencer_if.sv - operand/result handshake bundle for the folded CORDIC engine
interface cordic_iter_sequencer_if #(
  parameter int N = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x_in;
  logic [N-1:0] z_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] x_out;
  logic [N-1:0] z_out;
  logic         busy;

  modport master (
    output in_valid, x_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, z_out, busy
  );

  modport slave (
    input  in_valid, x_in, z_in, out_ready,
    output in_ready, out_valid, x_out, z_out, busy
  );

endinterface

// File: rtl/cordic_atanh_rom.sv
// rtl/cordic_atanh_rom.sv - combinational shift -> atanh(2^-shift) constant lookup at datapath scale
module cordic_atanh_rom
  import cordic_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [3:0]   shift,
  output logic [N-1:0] atanh_val
);

  assign atanh_val = N'(atanh_scaled(shift, N - FRAC_OFFSET));

endmodule

// File: rtl/cordic_iter_sequencer.sv
// rtl/cordic_iter_sequencer.sv - folded hyperbolic CORDIC: one add/shift datapath stepped by an FSM
module cordic_iter_sequencer
  import cordic_pkg::*;
#(
  parameter int N       = 16,
  parameter int ITER    = 12,
  parameter int REPEAT4 = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  cordic_iter_sequencer_if.slave  bus
);

  localparam int STEPS = ITER + REPEAT4;

  state_t       state;
  state_t       state_nx;
  logic [4:0]   step;
  logic [3:0]   shift;
  logic [N-1:0] x_r;
  logic [N-1:0] z_r;
  logic [N-1:0] x_shifted;
  logic [N-1:0] atanh_val;
  logic [N-1:0] x_nx;
  logic [N-1:0] z_nx;
  logic [N-1:0] x_out_r;
  logic [N-1:0] z_out_r;
  logic         last_step;
  logic         in_ready_c;
  logic         out_valid_c;
  logic         busy_c;

  assign shift     = step_shift(step, REPEAT4 != 0);
  assign last_step = (step == 5'(STEPS - 1));

  cordic_atanh_rom #(
    .N(N)
  ) u_atanh_rom (
    .shift     (shift),
    .atanh_val (atanh_val)
  );

  // Rotation direction follows the sign of the residual angle
  always_comb begin
    x_shifted = $signed(x_r) >>> shift;
    if (z_r[N-1]) begin
      x_nx = x_r - x_shifted;
      z_nx = z_r + atanh_val;
    end else begin
      x_nx = x_r + x_shifted;
      z_nx = z_r - atanh_val;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) begin
          state_nx = ITERATE;
        end
      end
      ITERATE: begin
        if (last_step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Result registers load only on the final step, so they hold through IDLE and the next job
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_r     <= '0;
      z_r     <= '0;
      step    <= '0;
      x_out_r <= '0;
      z_out_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x_r  <= bus.x_in;
            z_r  <= bus.z_in;
            step <= '0;
          end
        end
        ITERATE: begin
          x_r  <= x_nx;
          z_r  <= z_nx;
          step <= step + 5'd1;
          if (last_step) begin
            x_out_r <= x_nx;
            z_out_r <= z_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.x_out     = x_out_r;
  assign bus.z_out     = z_out_r;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// tb/tb_cordic_iter_sequencer.sv - scoreboard bench for the folded hyperbolic CORDIC engine
module tb_cordic_iter_sequencer;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;
  int   cyc;
  logic [31:0] exp_q [$];

  cordic_iter_sequencer_if #(.N(16)) bus ();

  cordic_iter_sequencer #(
    .N       (16),
    .ITER    (12),
    .REPEAT4 (1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: hyperbolic CORDIC with schedule 1,2,3,4,4,5..12 and real-valued atanh constants
  function automatic logic [31:0] model(input logic [15:0] x0, input logic [15:0] z0);
    logic [15:0] x;
    logic [15:0] z;
    logic [15:0] xs;
    logic [15:0] a;
    int          s;
    x = x0;
    z = z0;
    for (int k = 0; k < 13; k++) begin
      s  = (k < 4) ? k + 1 : k;
      xs = 16'($signed(x) >>> s);
      a  = 16'($rtoi($atanh(2.0 ** (-s)) * 8192.0 + 0.5));
      if (z[15]) begin
        x = x - xs;
        z = z + a;
      end else begin
        x = x + xs;
        z = z - a;
      end
    end
    return {x, z};
  endfunction

  task automatic send(input logic [15:0] x, input logic [15:0] z);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.z_in     = z;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    exp_q.push_back(model(x, z));
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic test_single(input string name, input logic [15:0] x, input logic [15:0] z,
                             output logic [15:0] xo, output logic [15:0] zo);
    int          n;
    logic [31:0] exp;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_in_ready: got %b want 1", name, bus.in_ready);
    end
    send(x, z);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: in_ready=%b busy=%b want 0/1", name, bus.in_ready, bus.busy);
    end
    wait_out(n);
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want 13", name, n);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    checks++;
    if ({bus.x_out, bus.z_out} !== exp) begin
      errors++;
      $display("FAIL %s result: got x=%h z=%h want x=%h z=%h", name, bus.x_out, bus.z_out,
               exp[31:16], exp[15:0]);
    end
    xo = bus.x_out;
    zo = bus.z_out;
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b out_valid=%b in_ready=%b want 0/0/1", bus.busy, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.x_out !== 16'h0 || bus.z_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: x_out=%h z_out=%h want 0/0", bus.x_out, bus.z_out);
    end
  endtask

  task automatic test_basic();
    logic [15:0] xo, zo;
    test_single("basic", 16'h2000, 16'h0000, xo, zo);
  endtask

  task automatic test_zero_x();
    logic [15:0] xo, zo;
    test_single("zero_x", 16'h0000, 16'h1000, xo, zo);
    checks++;
    if (xo !== 16'h0000) begin
      errors++;
      $display("FAIL zero_x_exact: got %h want 0000", xo);
    end
  endtask

  task automatic test_backpressure();
    int          n;
    logic [31:0] exp;
    logic [15:0] xh, zh;
    bus.out_ready = 1'b0;
    send(16'h1800, 16'hF000);
    wait_out(n);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    checks++;
    if ({bus.x_out, bus.z_out} !== exp) begin
      errors++;
      $display("FAIL bp_result: got x=%h z=%h want x=%h z=%h", bus.x_out, bus.z_out, exp[31:16], exp[15:0]);
    end
    xh = bus.x_out;
    zh = bus.z_out;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.x_in     = 16'h1111 * 16'(i + 1);
      bus.z_in     = 16'h0100;
      @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.x_out !== xh || bus.z_out !== zh) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b x=%h z=%h want 1/0/%h/%h",
                 i, bus.out_valid, bus.in_ready, bus.x_out, bus.z_out, xh, zh);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] xo, zo;
    send(16'h2400, 16'h0800);
    repeat (6) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.x_out !== 16'h0 || bus.z_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b out_valid=%b in_ready=%b x=%h z=%h want 0/0/1/0/0",
               bus.busy, bus.out_valid, bus.in_ready, bus.x_out, bus.z_out);
    end
    test_single("after_reset", 16'h1c00, 16'hF400, xo, zo);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops_x [4];
    logic [15:0] ops_z [4];
    logic [31:0] exp;
    logic [15:0] xs, zs;
    logic        acc, outv, rdy;
    int          idx, got, last_res;
    for (int i = 0; i < 4; i++) begin
      ops_x[i] = 16'($urandom_range(16'h3000, 16'h0400));
      ops_z[i] = 16'($urandom);
    end
    idx = 0;
    got = 0;
    last_res = -1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x_in      = ops_x[0];
    bus.z_in      = ops_z[0];
    for (int c = 0; c < 120 && got < 4; c++) begin
      acc  = bus.in_ready && bus.in_valid;
      outv = bus.out_valid;
      rdy  = bus.in_ready;
      xs   = bus.x_out;
      zs   = bus.z_out;
      @(posedge clock);
      #1;
      if (acc) begin
        exp_q.push_back(model(ops_x[idx], ops_z[idx]));
        idx++;
        if (idx == 4) begin
          bus.in_valid = 1'b0;
        end else begin
          bus.x_in = ops_x[idx];
          bus.z_in = ops_z[idx];
        end
      end
      if (outv) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        checks++;
        if ({xs, zs} !== exp || rdy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got x=%h z=%h in_ready=%b want x=%h z=%h in_ready=0",
                   got, xs, zs, rdy, exp[31:16], exp[15:0]);
        end
        if (last_res >= 0) begin
          checks++;
          if (cyc - last_res != 15) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles want 15", got, cyc - last_res);
          end
        end
        last_res = cyc;
        got++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 4", got);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] xo, zo;
    test_single("wrap_pos", 16'h7FFF, 16'h7000, xo, zo);
    test_single("sign_neg", 16'h8000, 16'h8000, xo, zo);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.z_in      = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_zero_x();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
